// File: rtl/pc_unit.sv
// Fetch-stage program counter with redirect/branch/jump/call/return sources
// and a circular return-address stack that overwrites its oldest entry when full.
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter int               STEP         = 1,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             stall_i,
  input  logic                             redirect_valid_i,
  input  logic [WIDTH-1:0]                 redirect_target_i,
  input  logic                             branch_taken_i,
  input  logic [WIDTH-1:0]                 branch_target_i,
  input  logic                             jump_i,
  input  logic [WIDTH-1:0]                 jump_target_i,
  input  logic                             call_i,
  input  logic                             ret_i,
  output logic [WIDTH-1:0]                 pc_o,
  output logic [WIDTH-1:0]                 pc_plus_o,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count_o,
  output logic                             ras_underflow_o
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH+1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             uf_q, uf_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic             push_s;
  logic [PW-1:0]    wr_idx_s;
  logic [WIDTH-1:0] pc_plus_s;

  assign pc_plus_s       = pc_q + WIDTH'(STEP);
  assign pc_plus_o       = pc_plus_s;
  assign pc_o            = pc_q;
  assign ras_count_o     = cnt_q;
  assign ras_underflow_o = uf_q;

  // Next-PC selection and stack bookkeeping, highest priority source first.
  always_comb begin
    pc_d     = pc_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    uf_d     = 1'b0;
    push_s   = 1'b0;
    wr_idx_s = ptr_q;
    if (redirect_valid_i) begin
      pc_d = redirect_target_i;
    end else if (stall_i) begin
      pc_d = pc_q;
    end else if (ret_i) begin
      if (cnt_q != CW'(0)) begin
        pc_d = ras_q[ptr_q - PW'(1)];
        if (call_i) begin
          // Pop and push in one cycle: the return address replaces the top.
          push_s   = 1'b1;
          wr_idx_s = ptr_q - PW'(1);
        end else begin
          ptr_d = ptr_q - PW'(1);
          cnt_d = cnt_q - CW'(1);
        end
      end else begin
        pc_d = pc_plus_s;
        uf_d = 1'b1;
        if (call_i) begin
          push_s = 1'b1;
          ptr_d  = ptr_q + PW'(1);
          cnt_d  = CW'(1);
        end else begin
          push_s = 1'b0;
        end
      end
    end else if (branch_taken_i) begin
      pc_d = branch_target_i;
    end else if (jump_i) begin
      pc_d = jump_target_i;
      if (call_i) begin
        push_s = 1'b1;
        ptr_d  = ptr_q + PW'(1);
        cnt_d  = (cnt_q == CW'(RAS_DEPTH)) ? cnt_q : cnt_q + CW'(1);
      end else begin
        push_s = 1'b0;
      end
    end else begin
      pc_d = pc_plus_s;
    end
  end

  // Architectural state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q  <= RESET_VECTOR;
      ptr_q <= PW'(0);
      cnt_q <= CW'(0);
      uf_q  <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      uf_q  <= uf_d;
    end
  end

  // Stack storage is left uninitialised; the count hides stale entries.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_s) begin
      ras_q[wr_idx_s] <= pc_plus_s;
    end
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the fetch stage of the pipelined MIPS core. It holds the architectural fetch PC and selects the next PC each cycle. Sources are sequential increment, branch, jump, call/return through an internal return-address stack (RAS), and a late pipeline redirect. It adds stall hold, a configurable reset vector and step, and RAS overflow and underflow handling.

Parameters:
WIDTH, 32, PC width in bits.
STEP, 1, sequential increment in address units (word-addressed instruction memory).
RESET_VECTOR, 0, PC value loaded on reset.
RAS_DEPTH, 4, return-address stack entries (>=2, power of two).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
stall  input  1  hold PC and RAS this cycle.
redirect_valid  input  1  late-stage flush/redirect request.
redirect_target  input  WIDTH  redirect destination.
branch_taken  input  1  resolved taken branch.
branch_target  input  WIDTH  branch destination.
jump  input  1  unconditional jump (j/jal).
jump_target  input  WIDTH  jump/call destination.
call  input  1  qualifies jump as a call (jal); pushes the return address.
ret  input  1  return (jr $ra); pops the RAS.
pc  output  WIDTH  current fetch PC (registered).
pc_plus  output  WIDTH  pc+STEP (combinational, mod 2^WIDTH).
ras_count  output  clog2(RAS_DEPTH+1)  valid RAS entries (registered).
ras_underflow  output  1  one-cycle registered pulse: ret with empty RAS.

Behaviour:
- All state updates on rising clk. Latency is one cycle: inputs sampled at edge N set pc after edge N.
- Reset (rst=1 at edge): pc=RESET_VECTOR, ras_count=0, ras_underflow=0, RAS pointer=0. Reset overrides every other input, including mid-call/mid-stall.
- Priority, highest first: rst > redirect_valid > stall > ret > branch_taken > jump.
- redirect_valid: pc<=redirect_target. RAS is unchanged. Applies even when stall=1.
- stall (no redirect): pc, RAS, and ras_count hold. ras_underflow<=0. ret/call/branch/jump are ignored.
- ret with ras_count>0: pc<=top entry; pointer decrements; ras_count decrements.
- ret with ras_count=0: pc<=pc+STEP; ras_underflow<=1 for one cycle; count stays 0.
- ret and call together: pc<=popped top (or pc+STEP if empty, with underflow pulse). pc+STEP is then pushed, so the top is replaced and the count is unchanged if it was non-empty. If empty, count becomes 1.
- branch_taken (no ret): pc<=branch_target. jump/call are ignored.
- jump (no ret/branch): pc<=jump_target. If call=1, push pc+STEP.
- call without jump is ignored.
- Push when ras_count=RAS_DEPTH: circular overwrite of the oldest entry. Count saturates at RAS_DEPTH and no error is flagged.
- Otherwise: pc<=pc+STEP, with wrap-around mod 2^WIDTH (e.g. 0xFFFFFFFF+1 -> 0).
- ras_underflow is 0 in every cycle except the one following an empty-stack ret.
- RAS storage is not cleared by reset. Only the pointer and count reset, so stale entries are never observable.

Test Plan:
- Reset/sequential: rst=1 for 2 cycles, then 4 idle cycles -> pc=0,1,2,3,4; ras_count=0. Repeat with RESET_VECTOR=0x100 -> pc=0x100 after reset.
- Stall/redirect: at pc=5 assert stall 3 cycles -> pc stays 5. Stall+redirect_valid(target 0x40) -> pc=0x40 next cycle. Stall+branch_taken -> pc stays 5.
- Call/return nesting: at pc=0x10, jump+call target 0x80 -> pc=0x80, count=1. At pc=0x81, call target 0xC0 -> count=2. Two rets -> pc=0x82 then 0x11, count=0.
- Overflow/underflow: 5 calls from pcs A..E with RAS_DEPTH=4 -> count=4. 4 rets return E+1,D+1,C+1,B+1. 5th ret -> pc=prev+1, ras_underflow=1 for exactly one cycle.
- Priority/simultaneous: branch_taken(0x20)+jump(0x30) -> pc=0x20. ret+branch_taken with count=1 (top 0x50) -> pc=0x50. ret+call at pc=0x60 with top 0x70 -> pc=0x70, top=0x61, count unchanged.
- Wrap and reset mid-operation: pc=0xFFFFFFFF idle -> pc=0. Push 2 entries, then rst=1 coincident with ret -> pc=RESET_VECTOR, count=0. A following ret -> underflow pulse.
